// File: rtl/rip_axi_arbiter.sv
// Round-robin sharing of one rip_axi_master write/read access-port pair between
// NUM_REQ requesters; each channel holds its grant until the master's done pulse.

module rip_axi_arb_chan #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               m_ready_i,
  input  logic               m_done_i,
  output logic [IW-1:0]      winner_o,
  output logic               m_valid_o,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [NUM_REQ-1:0] req_done_o,
  output logic               busy_o
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        st_q, st_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx_w;
  int            idx;

  // Scan downwards so the lowest offset from last_q (highest priority) wins.
  always_comb begin
    winner_o = '0;
    idx      = 0;
    idx_w    = '0;
    if (rstn) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(last_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_w = IW'(idx);
        if (req_valid_i[idx_w]) winner_o = idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q   <= ST_IDLE;
      gnt_q  <= '0;
      last_q <= IW'(NUM_REQ - 1);
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    m_valid_o   = 1'b0;
    req_ready_o = '0;
    req_done_o  = '0;
    case (st_q)
      ST_IDLE: begin
        m_valid_o = |req_valid_i;
        if (m_valid_o && m_ready_i) begin
          req_ready_o[winner_o] = 1'b1;
          gnt_d                 = winner_o;
          last_d                = winner_o;
          st_d                  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_done_o[gnt_q] = m_done_i;
        if (m_done_i) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    // Handshake outputs are held low combinationally while reset is asserted.
    if (!rstn) begin
      m_valid_o   = 1'b0;
      req_ready_o = '0;
      req_done_o  = '0;
    end
  end

  assign busy_o = (st_q == ST_BUSY);

endmodule

module rip_axi_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 1,
  parameter int B_WIDTH    = 8,
  localparam int LINE      = DATA_WIDTH * BURST_LEN,
  localparam int STRB      = LINE / B_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_wvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [NUM_REQ*LINE-1:0]       req_wdata,
  input  logic [NUM_REQ*STRB-1:0]       req_wstrb,
  output logic [NUM_REQ-1:0]            req_wready,
  output logic [NUM_REQ-1:0]            req_wdone,
  input  logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_raddr,
  output logic [NUM_REQ-1:0]            req_rready,
  output logic [LINE-1:0]               req_rdata,
  output logic [NUM_REQ-1:0]            req_rdone,
  input  logic                          m_wready,
  output logic [ADDR_WIDTH-1:0]         m_waddr,
  output logic [LINE-1:0]               m_wdata,
  output logic [STRB-1:0]               m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wdone,
  input  logic                          m_rready,
  output logic [ADDR_WIDTH-1:0]         m_raddr,
  output logic                          m_rvalid,
  input  logic [LINE-1:0]               m_rdata,
  input  logic                          m_rdone,
  output logic                          dbg_wbusy_o,
  output logic                          dbg_rbusy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Request side: valid/ready handshake completes in the cycle both are high;
  // a requester holds valid and payload until its one-hot ready bit is seen.
  logic [IW-1:0] wwin, rwin;

  rip_axi_arb_chan #(.NUM_REQ(NUM_REQ), .IW(IW)) u_wr (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_wvalid),
    .m_ready_i   (m_wready),
    .m_done_i    (m_wdone),
    .winner_o    (wwin),
    .m_valid_o   (m_wvalid),
    .req_ready_o (req_wready),
    .req_done_o  (req_wdone),
    .busy_o      (dbg_wbusy_o)
  );

  rip_axi_arb_chan #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rd (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_rvalid),
    .m_ready_i   (m_rready),
    .m_done_i    (m_rdone),
    .winner_o    (rwin),
    .m_valid_o   (m_rvalid),
    .req_ready_o (req_rready),
    .req_done_o  (req_rdone),
    .busy_o      (dbg_rbusy_o)
  );

  assign m_waddr   = req_waddr[int'(wwin)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_wdata   = req_wdata[int'(wwin)*LINE +: LINE];
  assign m_wstrb   = req_wstrb[int'(wwin)*STRB +: STRB];
  assign m_raddr   = req_raddr[int'(rwin)*ADDR_WIDTH +: ADDR_WIDTH];
  // Read data is only meaningful in the requester's rdone cycle.
  assign req_rdata = m_rdata;

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// Directed bench for rip_axi_arbiter: scoreboard queues filled by the stimulus,
// drained by a negedge monitor whenever a ready or done pulse appears.

module tb_rip_axi_arbiter;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int LINE = 32;
  localparam int STRB = 4;
  localparam int WA_W = N + AW + LINE + STRB;
  localparam int RA_W = N + AW;
  localparam int RD_W = N + LINE;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N-1:0]      req_wvalid = '0;
  logic [N*AW-1:0]   req_waddr = '0;
  logic [N*LINE-1:0] req_wdata = '0;
  logic [N*STRB-1:0] req_wstrb = '0;
  logic [N-1:0]      req_wready, req_wdone;
  logic [N-1:0]      req_rvalid = '0;
  logic [N*AW-1:0]   req_raddr = '0;
  logic [N-1:0]      req_rready, req_rdone;
  logic [LINE-1:0]   req_rdata;
  logic              m_wready = 1'b0;
  logic [AW-1:0]     m_waddr;
  logic [LINE-1:0]   m_wdata;
  logic [STRB-1:0]   m_wstrb;
  logic              m_wvalid;
  logic              m_wdone = 1'b0;
  logic              m_rready = 1'b0;
  logic [AW-1:0]     m_raddr;
  logic              m_rvalid;
  logic [LINE-1:0]   m_rdata = '0;
  logic              m_rdone = 1'b0;
  logic              dbg_wbusy, dbg_rbusy;

  int errors = 0;
  int checks = 0;

  logic [WA_W-1:0] wacc_q[$];
  logic [N-1:0]    wdone_q[$];
  logic [RA_W-1:0] racc_q[$];
  logic [RD_W-1:0] rdone_q[$];

  rip_axi_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BURST_LEN(1)) dut (
    .clk(clk), .rstn(rstn),
    .req_wvalid(req_wvalid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wready(req_wready), .req_wdone(req_wdone),
    .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rdone(req_rdone),
    .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wdone(m_wdone),
    .m_rready(m_rready), .m_raddr(m_raddr), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_rdone(m_rdone),
    .dbg_wbusy_o(dbg_wbusy), .dbg_rbusy_o(dbg_rbusy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_w(input int i, input logic [AW-1:0] a, input logic [LINE-1:0] d,
                       input logic [STRB-1:0] s);
    req_waddr[i*AW +: AW]     = a;
    req_wdata[i*LINE +: LINE] = d;
    req_wstrb[i*STRB +: STRB] = s;
  endtask

  task automatic exp_wacc(input logic [N-1:0] oh, input logic [AW-1:0] a,
                          input logic [LINE-1:0] d, input logic [STRB-1:0] s);
    wacc_q.push_back({oh, a, d, s});
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic [WA_W-1:0] mw_e;
  logic [N-1:0]    mwd_e;
  logic [RA_W-1:0] mr_e;
  logic [RD_W-1:0] mrd_e;

  always @(negedge clk) begin
    if (req_wready != '0) begin
      checks++;
      if (wacc_q.size() == 0) begin
        errors++;
        $display("FAIL wr_accept: unexpected ready=%b addr=%h", req_wready, m_waddr);
      end else begin
        mw_e = wacc_q.pop_front();
        if ({req_wready, m_waddr, m_wdata, m_wstrb} !== mw_e) begin
          errors++;
          $display("FAIL wr_accept: got %h expected %h",
                   {req_wready, m_waddr, m_wdata, m_wstrb}, mw_e);
        end
      end
    end
    if (req_wdone != '0) begin
      checks++;
      if (wdone_q.size() == 0) begin
        errors++;
        $display("FAIL wr_done: unexpected done=%b", req_wdone);
      end else begin
        mwd_e = wdone_q.pop_front();
        if (req_wdone !== mwd_e) begin
          errors++;
          $display("FAIL wr_done: got %b expected %b", req_wdone, mwd_e);
        end
      end
    end
    if (req_rready != '0) begin
      checks++;
      if (racc_q.size() == 0) begin
        errors++;
        $display("FAIL rd_accept: unexpected ready=%b addr=%h", req_rready, m_raddr);
      end else begin
        mr_e = racc_q.pop_front();
        if ({req_rready, m_raddr} !== mr_e) begin
          errors++;
          $display("FAIL rd_accept: got %h expected %h", {req_rready, m_raddr}, mr_e);
        end
      end
    end
    if (req_rdone != '0) begin
      checks++;
      if (rdone_q.size() == 0) begin
        errors++;
        $display("FAIL rd_done: unexpected done=%b", req_rdone);
      end else begin
        mrd_e = rdone_q.pop_front();
        if ({req_rdone, req_rdata} !== mrd_e) begin
          errors++;
          $display("FAIL rd_done: got %h expected %h", {req_rdone, req_rdata}, mrd_e);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    // Reset with everything driven active: outputs must stay low, payload shows slice 0.
    req_wvalid = 2'b11; req_rvalid = 2'b11; m_wready = 1'b1; m_rready = 1'b1;
    m_wdone = 1'b1; m_rdone = 1'b1;
    set_w(0, 32'hAAAA0000, 32'h0, 4'h0);
    set_w(1, 32'hBBBB0000, 32'h0, 4'h0);
    step(); step();
    sample();
    chk("rst_wready", 96'(req_wready), 96'(0));
    chk("rst_rready", 96'(req_rready), 96'(0));
    chk("rst_wdone", 96'(req_wdone), 96'(0));
    chk("rst_rdone", 96'(req_rdone), 96'(0));
    chk("rst_mvalid", 96'({m_wvalid, m_rvalid}), 96'(0));
    chk("rst_waddr", 96'(m_waddr), 96'(32'hAAAA0000));
    step();
    rstn = 1'b1; req_wvalid = '0; req_rvalid = '0; m_wready = 1'b0; m_rready = 1'b0;
    m_wdone = 1'b0; m_rdone = 1'b0;
    sample();
    chk("post_rst_busy", 96'({dbg_wbusy, dbg_rbusy}), 96'(0));

    // Spurious done pulses in IDLE are ignored
    step();
    m_wdone = 1'b1; m_rdone = 1'b1;
    sample();
    chk("spurious_done", 96'({req_wdone, req_rdone}), 96'(0));
    step();
    m_wdone = 1'b0; m_rdone = 1'b0;

    // Single write, done three cycles after the handshake
    step();
    set_w(0, 32'h1000, 32'hDEADBEEF, 4'hF);
    req_wvalid = 2'b01; m_wready = 1'b1;
    exp_wacc(2'b01, 32'h1000, 32'hDEADBEEF, 4'hF);
    sample();
    chk("s1_mwvalid", 96'(m_wvalid), 96'(1));
    chk("s1_maddr", 96'(m_waddr), 96'(32'h1000));
    step();
    req_wvalid = '0; m_wready = 1'b0;
    sample();
    chk("s1_busy_mwvalid", 96'(m_wvalid), 96'(0));
    chk("s1_busy_state", 96'(dbg_wbusy), 96'(1));
    step();
    step();
    m_wdone = 1'b1;
    wdone_q.push_back(2'b01);
    sample();
    chk("s1_done_mwvalid", 96'(m_wvalid), 96'(0));
    step();
    m_wdone = 1'b0; m_wready = 1'b1;
    sample();
    chk("s1_idle_state", 96'(dbg_wbusy), 96'(0));

    // Read fairness: both requesters held valid, grants alternate 0,1,0,1
    step();
    req_raddr[0*AW +: AW] = 32'h2000;
    req_raddr[1*AW +: AW] = 32'h3000;
    req_rvalid = 2'b11; m_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      racc_q.push_back({N'(1) << (k % 2), (k % 2 == 0) ? 32'h2000 : 32'h3000});
      sample();
      chk("s2_mrvalid", 96'(m_rvalid), 96'(1));
      step();
      sample();
      chk("s2_busy_mrvalid", 96'(m_rvalid), 96'(0));
      step();
      m_rdone = 1'b1; m_rdata = 32'hA5A50000 + 32'(k);
      rdone_q.push_back({N'(1) << (k % 2), 32'hA5A50000 + 32'(k)});
      step();
      m_rdone = 1'b0;
      if (k == 3) req_rvalid = '0;
    end

    // Concurrent write (req 0) and read (req 1)
    step();
    set_w(0, 32'h4000, 32'h11112222, 4'h3);
    req_raddr[1*AW +: AW] = 32'h5000;
    req_wvalid = 2'b01; req_rvalid = 2'b10; m_wready = 1'b1; m_rready = 1'b1;
    exp_wacc(2'b01, 32'h4000, 32'h11112222, 4'h3);
    racc_q.push_back({2'b10, 32'h5000});
    sample();
    chk("s3_both_valid", 96'({m_wvalid, m_rvalid}), 96'(2'b11));
    step();
    req_wvalid = '0; req_rvalid = '0;
    step();
    m_wdone = 1'b1; m_rdone = 1'b1; m_rdata = 32'hCAFEF00D;
    wdone_q.push_back(2'b01);
    rdone_q.push_back({2'b10, 32'hCAFEF00D});
    step();
    m_wdone = 1'b0; m_rdone = 1'b0;

    // Requester 1 stalls while requester 0 owns the write channel
    step();
    set_w(0, 32'h6000, 32'h66666666, 4'hF);
    req_wvalid = 2'b01;
    exp_wacc(2'b01, 32'h6000, 32'h66666666, 4'hF);
    step();
    set_w(1, 32'h7000, 32'h77777777, 4'hC);
    req_wvalid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("s4_stall_ready", 96'(req_wready), 96'(0));
      chk("s4_stall_mwvalid", 96'(m_wvalid), 96'(0));
      step();
    end
    m_wdone = 1'b1;
    wdone_q.push_back(2'b01);
    sample();
    chk("s4_done_mwvalid", 96'(m_wvalid), 96'(0));
    chk("s4_done_ready", 96'(req_wready), 96'(0));
    step();
    m_wdone = 1'b0;
    exp_wacc(2'b10, 32'h7000, 32'h77777777, 4'hC);
    sample();
    chk("s4_reissue_mwvalid", 96'(m_wvalid), 96'(1));
    chk("s4_reissue_addr", 96'(m_waddr), 96'(32'h7000));
    step();
    req_wvalid = '0;
    step();
    m_wdone = 1'b1;
    wdone_q.push_back(2'b10);
    step();
    m_wdone = 1'b0;

    // Withdrawn requests after reset do not move the pointer
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    set_w(1, 32'h8000, 32'h88888888, 4'h8);
    req_wvalid = 2'b10; m_wready = 1'b0;
    sample();
    chk("s5_wd_mwvalid", 96'(m_wvalid), 96'(1));
    chk("s5_wd_addr", 96'(m_waddr), 96'(32'h8000));
    chk("s5_wd_ready", 96'(req_wready), 96'(0));
    step();
    req_wvalid = 2'b00;
    step();
    set_w(0, 32'h9000, 32'h99990000, 4'h1);
    req_wvalid = 2'b01;
    step();
    req_wvalid = 2'b00;
    step();
    req_wvalid = 2'b11; m_wready = 1'b1;
    exp_wacc(2'b01, 32'h9000, 32'h99990000, 4'h1);
    step();
    req_wvalid = 2'b10;
    step();
    m_wdone = 1'b1;
    wdone_q.push_back(2'b01);
    step();
    m_wdone = 1'b0;
    exp_wacc(2'b10, 32'h8000, 32'h88888888, 4'h8);
    step();
    req_wvalid = '0;
    step();
    m_wdone = 1'b1;
    wdone_q.push_back(2'b10);
    step();
    m_wdone = 1'b0;

    // Reset while BUSY for requester 1; first grant afterwards goes to 0
    step();
    set_w(1, 32'hA000, 32'hAAAA5555, 4'hF);
    req_wvalid = 2'b10; m_wready = 1'b1;
    exp_wacc(2'b10, 32'hA000, 32'hAAAA5555, 4'hF);
    step();
    req_wvalid = '0;
    sample();
    chk("s6_busy_state", 96'(dbg_wbusy), 96'(1));
    step();
    rstn = 1'b0; req_wvalid = 2'b11; req_rvalid = 2'b11; m_wdone = 1'b1; m_rdone = 1'b1;
    sample();
    chk("s6_rst_outputs", 96'({req_wready, req_wdone, req_rready, req_rdone, m_wvalid, m_rvalid}),
        96'(0));
    step();
    rstn = 1'b1; req_wvalid = '0; req_rvalid = '0; m_wdone = 1'b0; m_rdone = 1'b0;
    sample();
    chk("s6_idle_state", 96'(dbg_wbusy), 96'(0));
    chk("s6_idle_outputs", 96'({req_wready, req_wdone}), 96'(0));
    step();
    set_w(0, 32'hB000, 32'hBBBB0000, 4'h7);
    req_wvalid = 2'b11;
    exp_wacc(2'b01, 32'hB000, 32'hBBBB0000, 4'h7);
    step();
    req_wvalid = '0;
    step();
    m_wdone = 1'b1;
    wdone_q.push_back(2'b01);
    step();
    m_wdone = 1'b0;
    step();
    step();

    // Final report
    chk("left_wacc", 96'(wacc_q.size()), 96'(0));
    chk("left_wdone", 96'(wdone_q.size()), 96'(0));
    chk("left_racc", 96'(racc_q.size()), 96'(0));
    chk("left_rdone", 96'(rdone_q.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
